// File: rtl/chan_mux_scan.sv
// ============================================================================
// chan_mux_scan : registered N-lane selector with fixed / scan / sweep modes
// Revision      : 1.0
// ============================================================================
`default_nettype none

module chan_mux_scan #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS),
    parameter int DWELL_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic [1:0]                mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [DWELL_W-1:0]        dwell,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      scan_wrap,
    output logic                      sweep_done
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FIXED = 3'd1,
        ST_SCAN  = 3'd2,
        ST_SWEEP = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [SEL_W-1:0] c_last = SEL_W'(CHANNELS - 1);

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     ptr_q, ptr_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [SEL_W-1:0]     chan_q, chan_d;
    logic                 wrap_q, wrap_d;
    logic                 done_q, done_d;

    logic                 w_adv;
    logic                 w_xfer;
    logic                 w_load;
    logic                 w_sweep;
    logic [SEL_W-1:0]     w_sel_clamp;
    logic [WIDTH-1:0]     w_lane [CHANNELS];

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_lane
            assign w_lane[k] = data_in[k*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_adv       = !valid_q || out_ready;
    assign w_xfer      = valid_q && out_ready;
    assign w_sweep     = mode[0];
    assign w_sel_clamp = (32'(sel_in) >= 32'(CHANNELS)) ? c_last : sel_in;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        data_d  = data_q;
        chan_d  = chan_q;
        wrap_d  = 1'b0;
        done_d  = done_q;
        w_load  = 1'b0;

        if (w_adv) begin
            case (mode)
                2'b00: begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                end
                2'b01: begin
                    state_d = ST_FIXED;
                    ptr_d   = w_sel_clamp;
                    w_load  = 1'b1;
                end
                default: begin
                    if ((!w_sweep && state_q == ST_SCAN) || (w_sweep && state_q == ST_SWEEP)) begin
                        w_load = 1'b1;
                        // >= rather than == so a lowered dwell advances on the next transfer
                        if (w_xfer) begin
                            if (cnt_q >= dwell) begin
                                cnt_d = '0;
                                if (ptr_q == c_last) begin
                                    wrap_d = 1'b1;
                                    if (w_sweep) begin
                                        state_d = ST_DONE;
                                        done_d  = 1'b1;
                                        valid_d = 1'b0;
                                        w_load  = 1'b0;
                                    end else begin
                                        ptr_d = '0;
                                    end
                                end else begin
                                    ptr_d = ptr_q + 1'b1;
                                end
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end else if (w_sweep && state_q == ST_DONE) begin
                        valid_d = 1'b0;
                    end else begin
                        state_d = w_sweep ? ST_SWEEP : ST_SCAN;
                        ptr_d   = '0;
                        cnt_d   = '0;
                        done_d  = 1'b0;
                        w_load  = 1'b1;
                    end
                end
            endcase
        end

        if (w_load) begin
            valid_d = 1'b1;
            data_d  = w_lane[ptr_d];
            chan_d  = ptr_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            chan_q  <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_data   = data_q;
    assign out_chan   = chan_q;
    assign scan_wrap  = wrap_q;
    assign sweep_done = done_q;

endmodule

`default_nettype wire
